// File: rtl/cell_bist_pkg.sv
// Shared width, tap mask, FSM state type and the LFSR/MISR shift function
// used by the cell BIST controller.
package cell_bist_pkg;

    localparam int unsigned       BIST_W    = 16;
    localparam logic [BIST_W-1:0] BIST_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } bist_state_e;

    // Fibonacci shift: taps 15, 13, 12 and 10 feed bit 0.
    function automatic logic [BIST_W-1:0] bist_step(input logic [BIST_W-1:0] s);
        return {s[BIST_W-2:0], ^(s & BIST_TAPS)};
    endfunction

endpackage

// File: rtl/cell_bist_lfsr.sv
// 16-bit shift register: a plain Fibonacci LFSR (MISR=0) or a MISR that XORs
// a parallel input into each step (MISR=1). Reset > load > enable.
module cell_bist_lfsr
    import cell_bist_pkg::*;
#(
    parameter int unsigned MISR = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [BIST_W-1:0] load_val_i,
    input  logic              en_i,
    input  logic [BIST_W-1:0] din_i,
    output logic [BIST_W-1:0] state_o
);

    logic [BIST_W-1:0] state_q;
    logic [BIST_W-1:0] state_d;

    always_comb begin
        state_d = bist_step(state_q);
        if (MISR != 0) begin
            state_d = state_d ^ din_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= '0;
        end else if (load_i) begin
            state_q <= load_val_i;
        end else if (en_i) begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/cell_bist_ctrl.sv
// Cell BIST controller: LFSR pattern generator, MISR response compactor and
// run FSM. Define BIST_SIG_OUT_EN to expose the live MISR on port SIG.
module cell_bist_ctrl
    import cell_bist_pkg::*;
#(
    parameter int unsigned       NUM_PAT    = 1024,
    parameter logic [BIST_W-1:0] SEED       = 16'h0001,
    parameter logic [BIST_W-1:0] GOLDEN_SIG = 16'h0000
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              START,
    output logic [BIST_W-1:0] PAT,
    output logic              PAT_VLD,
    input  logic [BIST_W-1:0] RSP,
    output logic              BUSY,
    output logic              DONE,
    output logic              PASS
`ifdef BIST_SIG_OUT_EN
    ,
    output logic [BIST_W-1:0] SIG
`endif
);

    localparam logic [BIST_W-1:0] SEED_EFF = (SEED == '0) ? 16'h0001 : SEED;
    localparam logic [15:0]       PAT_LAST = 16'(NUM_PAT);

    bist_state_e       state_q;
    logic [15:0]       cnt_q;
    logic              pat_vld_q;
    logic              vld_dly_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic [BIST_W-1:0] pat_q;
    logic [BIST_W-1:0] sig_q;
    logic [BIST_W-1:0] sig_d;
    logic              start_ok;
    logic              last_pat;
    logic              lfsr_en;

    assign start_ok = START && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign last_pat = (cnt_q == PAT_LAST);
    assign lfsr_en  = (state_q == ST_RUN) && !last_pat;
    // Signature after the final compaction, which lands on the DRAIN cycle.
    assign sig_d    = bist_step(sig_q) ^ RSP;

    cell_bist_lfsr #(.MISR(0)) u_lfsr (
        .clk_i      (CK),
        .rst_i      (RST),
        .load_i     (start_ok),
        .load_val_i (SEED_EFF),
        .en_i       (lfsr_en),
        .din_i      ('0),
        .state_o    (pat_q)
    );

    cell_bist_lfsr #(.MISR(1)) u_misr (
        .clk_i      (CK),
        .rst_i      (RST),
        .load_i     (start_ok),
        .load_val_i ('0),
        .en_i       (vld_dly_q),
        .din_i      (RSP),
        .state_o    (sig_q)
    );

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pat_vld_q <= 1'b0;
            vld_dly_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            vld_dly_q <= pat_vld_q;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (START) begin
                        state_q   <= ST_RUN;
                        cnt_q     <= 16'd1;
                        pat_vld_q <= 1'b1;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        pass_q    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (last_pat) begin
                        state_q   <= ST_DRAIN;
                        pat_vld_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                ST_DRAIN: begin
                    state_q <= ST_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    pass_q  <= (sig_d == GOLDEN_SIG);
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign PAT     = pat_q;
    assign PAT_VLD = pat_vld_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign PASS    = pass_q;
`ifdef BIST_SIG_OUT_EN
    assign SIG     = sig_q;
`endif

endmodule

// File: tb/tb_cell_bist_ctrl.sv
// Self-checking bench for cell_bist_ctrl: cycle table plus pattern scoreboard
// on instance A, hand sequences on B/C (golden pass/fail) and D (SEED=0).
`timescale 1ns/1ps
module tb_cell_bist_ctrl;

    localparam logic [15:0] GOLDEN_A = 16'h0018;
    localparam logic [15:0] GOLDEN_D = 16'h8001;

    logic CK = 1'b0;
    logic RST = 1'b1;
    logic start_a = 1'b0, start_bc = 1'b0, start_d = 1'b0;
    logic [15:0] pat_a, pat_b, pat_c, pat_d;
    logic [15:0] rsp_a, rsp_ff, rsp_d;
    logic vld_a, vld_b, vld_c, vld_d;
    logic busy_a, busy_b, busy_c, busy_d;
    logic done_a, done_b, done_c, done_d;
    logic pass_a, pass_b, pass_c, pass_d;
`ifdef BIST_SIG_OUT_EN
    logic [15:0] sig_a, sig_b, sig_c, sig_d;
`endif

    always #5 CK = ~CK;

    assign rsp_a  = pat_a;
    assign rsp_ff = 16'hFFFF;
    assign rsp_d  = pat_d ^ 16'h8000;

    cell_bist_ctrl #(.NUM_PAT(4), .SEED(16'h0001), .GOLDEN_SIG(GOLDEN_A)) u_a (
        .CK(CK), .RST(RST), .START(start_a), .PAT(pat_a), .PAT_VLD(vld_a), .RSP(rsp_a),
        .BUSY(busy_a), .DONE(done_a), .PASS(pass_a)
`ifdef BIST_SIG_OUT_EN
        , .SIG(sig_a)
`endif
    );

    cell_bist_ctrl #(.NUM_PAT(2), .SEED(16'h0001), .GOLDEN_SIG(16'h0001)) u_b (
        .CK(CK), .RST(RST), .START(start_bc), .PAT(pat_b), .PAT_VLD(vld_b), .RSP(rsp_ff),
        .BUSY(busy_b), .DONE(done_b), .PASS(pass_b)
`ifdef BIST_SIG_OUT_EN
        , .SIG(sig_b)
`endif
    );

    cell_bist_ctrl #(.NUM_PAT(2), .SEED(16'h0001), .GOLDEN_SIG(16'h0000)) u_c (
        .CK(CK), .RST(RST), .START(start_bc), .PAT(pat_c), .PAT_VLD(vld_c), .RSP(rsp_ff),
        .BUSY(busy_c), .DONE(done_c), .PASS(pass_c)
`ifdef BIST_SIG_OUT_EN
        , .SIG(sig_c)
`endif
    );

    cell_bist_ctrl #(.NUM_PAT(1), .SEED(16'h0000), .GOLDEN_SIG(GOLDEN_D)) u_d (
        .CK(CK), .RST(RST), .START(start_d), .PAT(pat_d), .PAT_VLD(vld_d), .RSP(rsp_d),
        .BUSY(busy_d), .DONE(done_d), .PASS(pass_d)
`ifdef BIST_SIG_OUT_EN
        , .SIG(sig_d)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] sb_q[$];
    logic [15:0] sig_m = '0;
    logic prev_vld_m = 1'b0;
    logic prev_done_m = 1'b0;

    typedef struct {
        logic start;
        logic vld;
        logic busy;
        logic done;
        logic pass;
    } vec_t;
    vec_t tbl[8];

    function automatic logic [15:0] mstep(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CK);
        #1;
    endtask

    task automatic push_run(input logic [15:0] seed, input int n);
        logic [15:0] p;
        p = seed;
        for (int i = 0; i < n; i++) begin
            sb_q.push_back(p);
            p = mstep(p);
        end
    endtask

    // Scoreboard pop and signature model for instance A.
    always @(negedge CK) begin
        if (vld_a === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL A_extra_pat: got %h with no expected pattern", pat_a);
            end else begin
                chk16("A_pat", pat_a, sb_q.pop_front());
            end
        end
        if (RST) begin
            sig_m = '0;
        end else begin
            if (prev_vld_m) sig_m = mstep(sig_m) ^ rsp_a;
            if ((vld_a === 1'b1) && !prev_vld_m) sig_m = '0;
        end
        if ((done_a === 1'b1) && !prev_done_m)
            chk1("A_pass_vs_model", pass_a, sig_m == GOLDEN_A);
        prev_vld_m  = (vld_a === 1'b1);
        prev_done_m = (done_a === 1'b1);
    end

    initial begin
        tbl[0] = '{start: 1'b1, vld: 1'b0, busy: 1'b0, done: 1'b0, pass: 1'b0};
        tbl[1] = '{start: 1'b0, vld: 1'b1, busy: 1'b1, done: 1'b0, pass: 1'b0};
        tbl[2] = '{start: 1'b1, vld: 1'b1, busy: 1'b1, done: 1'b0, pass: 1'b0};
        tbl[3] = '{start: 1'b0, vld: 1'b1, busy: 1'b1, done: 1'b0, pass: 1'b0};
        tbl[4] = '{start: 1'b0, vld: 1'b1, busy: 1'b1, done: 1'b0, pass: 1'b0};
        tbl[5] = '{start: 1'b0, vld: 1'b0, busy: 1'b1, done: 1'b0, pass: 1'b0};
        tbl[6] = '{start: 1'b0, vld: 1'b0, busy: 1'b0, done: 1'b1, pass: 1'b1};
        tbl[7] = '{start: 1'b0, vld: 1'b0, busy: 1'b0, done: 1'b1, pass: 1'b1};

        // Reset state
        repeat (3) cyc();
        chk16("rst_pat_a", pat_a, 16'h0000);
        chk1("rst_vld_a", vld_a, 1'b0);
        chk1("rst_busy_a", busy_a, 1'b0);
        chk1("rst_done_a", done_a, 1'b0);
        chk1("rst_pass_a", pass_a, 1'b0);
        chk16("rst_pat_d", pat_d, 16'h0000);
        chk1("rst_done_d", done_d, 1'b0);
`ifdef BIST_SIG_OUT_EN
        chk16("rst_sig_a", sig_a, 16'h0000);
`endif
        RST = 1'b0;

        // A: full run with a START pulse during RUN that must be ignored
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk1($sformatf("A_vld_c%0d", i), vld_a, tbl[i].vld);
            chk1($sformatf("A_busy_c%0d", i), busy_a, tbl[i].busy);
            chk1($sformatf("A_done_c%0d", i), done_a, tbl[i].done);
            chk1($sformatf("A_pass_c%0d", i), pass_a, tbl[i].pass);
            if (tbl[i].start && !tbl[i].busy) push_run(16'h0001, 4);
            start_a = tbl[i].start;
        end
        chk16("A_pats_left", 16'(sb_q.size()), 16'd0);

        // A: reset at cycle 3 aborts the run, then a fresh run restarts at SEED
        cyc(); start_a = 1'b1; push_run(16'h0001, 4);
        cyc(); start_a = 1'b0;
        cyc();
        cyc(); RST = 1'b1;
        cyc(); RST = 1'b0; sb_q.delete();
        chk1("A_abort_vld", vld_a, 1'b0);
        chk1("A_abort_busy", busy_a, 1'b0);
        chk16("A_abort_pat", pat_a, 16'h0000);
        repeat (4) begin
            cyc();
            chk1("A_abort_no_done", done_a, 1'b0);
        end
        start_a = 1'b1; push_run(16'h0001, 4);
        cyc(); start_a = 1'b0;
        chk16("A_restart_pat", pat_a, 16'h0001);
        repeat (5) cyc();
        chk1("A_restart_done", done_a, 1'b1);
        chk1("A_restart_pass", pass_a, 1'b1);
        chk16("A_restart_pats_left", 16'(sb_q.size()), 16'd0);

        // B/C: RSP=FFFF, two patterns, final signature 0001
        cyc(); start_bc = 1'b1;
        cyc(); start_bc = 1'b0;
        chk1("B_vld_c1", vld_b, 1'b1);
        chk1("C_vld_c1", vld_c, 1'b1);
        chk16("B_pat_c1", pat_b, 16'h0001);
        chk16("C_pat_c1", pat_c, 16'h0001);
        cyc(); cyc();
        chk1("B_done_c3", done_b, 1'b0);
        chk1("B_busy_c3", busy_b, 1'b1);
        cyc();
        chk1("B_done_c4", done_b, 1'b1);
        chk1("B_pass_golden1", pass_b, 1'b1);
        chk1("C_done_c4", done_c, 1'b1);
        chk1("C_pass_golden0", pass_c, 1'b0);
        chk1("C_busy_c4", busy_c, 1'b0);

        // D: SEED=0 maps to 0001, single pattern, restart from DONE
        cyc(); start_d = 1'b1;
        cyc(); start_d = 1'b0;
        chk16("D_pat_c1", pat_d, 16'h0001);
        chk1("D_vld_c1", vld_d, 1'b1);
        cyc();
        chk1("D_vld_c2", vld_d, 1'b0);
        chk1("D_busy_c2", busy_d, 1'b1);
        chk1("D_done_c2", done_d, 1'b0);
        cyc();
        chk1("D_done_c3", done_d, 1'b1);
        chk1("D_pass_c3", pass_d, 1'b1);
        chk1("D_busy_c3", busy_d, 1'b0);
        start_d = 1'b1;
        cyc(); start_d = 1'b0;
        chk1("D_re_vld", vld_d, 1'b1);
        chk16("D_re_pat", pat_d, 16'h0001);
        chk1("D_re_done", done_d, 1'b0);
        chk1("D_re_pass", pass_d, 1'b0);
        cyc(); cyc();
        chk1("D_re_done_c3", done_d, 1'b1);
        chk1("D_re_pass_cleared", pass_d, 1'b1);

        // RST wins over START in the same cycle
        cyc(); RST = 1'b1; start_d = 1'b1;
        cyc(); RST = 1'b0; start_d = 1'b0;
        chk1("D_rst_prio_busy", busy_d, 1'b0);
        chk1("D_rst_prio_vld", vld_d, 1'b0);
        chk1("D_rst_prio_done", done_d, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cell_bist_ctrl.md
CELL_BIST_CTRL -- requirements
Module: cell_bist_ctrl

Interface
REQ-001 Parameter NUM_PAT, default 1024, meaning number of patterns per run; the legal range is 1..65535.
REQ-002 Parameter SEED, default 16'h0001, meaning initial LFSR state; a value of 0 SHALL be replaced by 16'h0001.
REQ-003 Parameter GOLDEN_SIG, default 16'h0000, meaning the expected final MISR signature.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high; ports CK and RST.
REQ-005 CK  input  1  rising-edge clock.
REQ-006 RST  input  1  synchronous, active-high reset.
REQ-007 START  input  1  single-cycle run request.
REQ-008 PAT  output  16  stimulus to the cell-under-test inputs.
REQ-009 PAT_VLD  output  1  PAT carries a pattern this cycle.
REQ-010 RSP  input  16  cell-under-test response, combinational from PAT.
REQ-011 BUSY  output  1  run in progress.
REQ-012 DONE  output  1  run complete; held until the next START or RST.
REQ-013 PASS  output  1  final signature equals GOLDEN_SIG; qualified by DONE.

Function
REQ-014 FSM states SHALL be IDLE, RUN, DRAIN and DONE.
REQ-015 FSM transitions SHALL be: IDLE->RUN on START; RUN->DRAIN after NUM_PAT patterns are issued; DRAIN->DONE after 1 cycle; DONE->RUN on START.
REQ-016 The LFSR SHALL be Fibonacci: next = {s[14:0], s[15]^s[13]^s[12]^s[10]}.
REQ-017 PAT SHALL be registered: SEED in the first RUN cycle, then one LFSR step per RUN cycle; PAT_VLD=1 in RUN only.
REQ-018 RSP SHALL be sampled exactly 1 cycle after each PAT_VLD cycle, using a delayed valid flop.
REQ-019 The MISR SHALL compute sig_next = {sig[14:0], sig[15]^sig[13]^sig[12]^sig[10]} ^ RSP on each sample cycle, with 16-bit wrap and no carry.
REQ-020 Entering RUN SHALL clear sig to 0 and reload the LFSR with SEED.
REQ-021 Timing: START at cycle 0 gives PAT_VLD on cycles 1..NUM_PAT, compaction on cycles 2..NUM_PAT+1, and DONE=1 from cycle NUM_PAT+2.
REQ-022 BUSY SHALL be 1 in RUN and DRAIN, else 0; START while BUSY SHALL be ignored.
REQ-023 PASS SHALL be 1 only in DONE with sig==GOLDEN_SIG, else 0.
REQ-024 The pattern counter SHALL be 16-bit and SHALL NOT wrap; NUM_PAT=1 gives a single pattern and a single compaction.
REQ-025 PAT SHALL hold its last value outside RUN.

Reset
REQ-026 RST SHALL force state=IDLE, PAT=0, PAT_VLD=0, BUSY=0, DONE=0, PASS=0, sig=0, counter=0 and delayed valid=0 at the next CK edge.
REQ-027 RST SHALL take priority over START in the same cycle.
REQ-028 RST mid-run SHALL abort the run with no DONE pulse.

Configuration
REQ-029 With BIST_SIG_OUT_EN defined, an output SIG (16, output) SHALL present the live MISR register (0 after reset).
REQ-030 Without BIST_SIG_OUT_EN, port SIG SHALL be absent; all other behaviour is identical.

Structure
REQ-031 Package cell_bist_pkg SHALL hold the FSM state enum, the width constant (16) and the tap-mask constant (16'hB400).
REQ-032 Sub-module cell_bist_lfsr (parameter MISR: 0 = plain LFSR, 1 = XOR parallel input) SHALL be instantiated twice, once as the LFSR and once as the MISR.

Verification
REQ-033 After RST: PAT=0000, PAT_VLD=0, BUSY=0, DONE=0, PASS=0.
REQ-034 NUM_PAT=4, SEED=0001, START -> PAT 0001, 0002, 0004, 0008 on cycles 1-4; DONE at cycle 6.
REQ-035 NUM_PAT=2, RSP tied to FFFF, GOLDEN_SIG=0001 -> final sig 0001 and PASS=1; with GOLDEN_SIG=0000 -> PASS=0.
REQ-036 START pulsed in RUN at cycle 2 -> ignored; pattern count stays 4; DONE at cycle 6.
REQ-037 RST at cycle 3 of a run -> IDLE next cycle, DONE never asserts; a subsequent START gives PAT=SEED again.
REQ-038 SEED=0, NUM_PAT=1 -> PAT=0001 on a single cycle, DONE at cycle 3; START in DONE restarts the run with sig cleared.
